// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared spiking-network types and weight packing constants
package snn_pkg;

    localparam int NUM_PRE = 4;
    localparam int W_WIDTH = 4;

    typedef enum logic [1:0] {
        INTEGRATE = 2'd0,
        FIRE      = 2'd1,
        REFRACT   = 2'd2
    } neuron_state_t;

endpackage

// File: rtl/weighted_spike_adder.sv
// rtl/weighted_spike_adder.sv - sums the packed weights of the active presynaptic inputs
module weighted_spike_adder #(
    parameter int NUM_PRE = 4,
    parameter int W_WIDTH = 4,
    parameter int SUM_W   = W_WIDTH + $clog2(NUM_PRE)
) (
    input  logic [NUM_PRE-1:0]         pre_spike_i,
    input  logic [NUM_PRE*W_WIDTH-1:0] weight_i,
    output logic [SUM_W-1:0]           sum_o
);

    // Input 0 owns the most significant weight slice, matching the STDP packing.
    always_comb begin
        sum_o = '0;
        for (int i = 0; i < NUM_PRE; i++) begin
            if (pre_spike_i[i]) begin
                sum_o = sum_o + SUM_W'(weight_i[(NUM_PRE-1-i)*W_WIDTH +: W_WIDTH]);
            end
        end
    end

endmodule

// File: rtl/lif_post_neuron.sv
// rtl/lif_post_neuron.sv - leaky integrate-and-fire postsynaptic neuron with refractory period
module lif_post_neuron #(
    parameter int NUM_PRE       = snn_pkg::NUM_PRE,
    parameter int W_WIDTH       = snn_pkg::W_WIDTH,
    parameter int V_WIDTH       = 8,
    parameter int THRESHOLD     = 32,
    parameter int LEAK          = 1,
    parameter int REFRAC_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NUM_PRE-1:0]         pre_spike,
    input  logic [NUM_PRE*W_WIDTH-1:0] weight,
    output logic                       post_spike,
    output logic [V_WIDTH-1:0]         membrane,
    output logic                       refractory,
    output logic [7:0]                 spike_count
);

    import snn_pkg::*;

    localparam int SUM_W = W_WIDTH + $clog2(NUM_PRE);
    localparam int CNT_W = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
    localparam logic [V_WIDTH-1:0] THR_V    = V_WIDTH'(THRESHOLD);
    localparam logic [V_WIDTH-1:0] LEAK_V   = V_WIDTH'(LEAK);
    localparam logic [CNT_W-1:0]   REFRAC_V = CNT_W'(REFRAC_CYCLES);

    neuron_state_t      state_q, state_d;
    logic [V_WIDTH-1:0] membrane_q, membrane_d;
    logic               post_q, post_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         count_q, count_d;

    logic [SUM_W-1:0]   sum;
    logic [V_WIDTH-1:0] leaked;
    logic [V_WIDTH:0]   nxt_wide;
    logic [V_WIDTH-1:0] nxt_sat;

    weighted_spike_adder #(
        .NUM_PRE (NUM_PRE),
        .W_WIDTH (W_WIDTH),
        .SUM_W   (SUM_W)
    ) u_adder (
        .pre_spike_i (pre_spike),
        .weight_i    (weight),
        .sum_o       (sum)
    );

    // Leak floors at zero; the extra carry bit lets the add saturate instead of wrapping.
    assign leaked   = (membrane_q > LEAK_V) ? (membrane_q - LEAK_V) : '0;
    assign nxt_wide = {1'b0, leaked} + (V_WIDTH + 1)'(sum);
    assign nxt_sat  = nxt_wide[V_WIDTH] ? '1 : nxt_wide[V_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= INTEGRATE;
            membrane_q <= '0;
            post_q     <= 1'b0;
            cnt_q      <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            membrane_q <= membrane_d;
            post_q     <= post_d;
            cnt_q      <= cnt_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        membrane_d = membrane_q;
        post_d     = post_q;
        cnt_d      = cnt_q;
        count_d    = count_q;
        unique case (state_q)
            INTEGRATE: begin
                if (en) begin
                    if (nxt_sat >= THR_V) begin
                        membrane_d = '0;
                        post_d     = 1'b1;
                        state_d    = FIRE;
                        if (count_q != 8'hFF) begin
                            count_d = count_q + 8'd1;
                        end
                    end else begin
                        membrane_d = nxt_sat;
                    end
                end
            end
            FIRE: begin
                post_d = 1'b0;
                if (REFRAC_CYCLES == 0) begin
                    state_d = INTEGRATE;
                end else begin
                    state_d = REFRACT;
                    cnt_d   = REFRAC_V;
                end
            end
            REFRACT: begin
                membrane_d = '0;
                if (en) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = INTEGRATE;
                    end
                end
            end
            default: begin
                state_d = INTEGRATE;
            end
        endcase
    end

    assign post_spike  = post_q;
    assign membrane    = membrane_q;
    assign refractory  = (state_q != INTEGRATE);
    assign spike_count = count_q;

endmodule

// File: tb/tb_lif_post_neuron.sv
// tb/tb_lif_post_neuron.sv - directed self-checking bench for lif_post_neuron
module tb_lif_post_neuron;

    logic        clk;
    logic        rst_n;
    logic        en, en_b;
    logic [3:0]  pre_spike, pre_b;
    logic [15:0] weight, weight_b;
    logic        post_spike, post_b;
    logic [7:0]  membrane, membrane_b;
    logic        refractory, refr_b;
    logic [7:0]  spike_count, count_b;

    int n_checks = 0;
    int n_fail   = 0;

    lif_post_neuron dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pre_spike   (pre_spike),
        .weight      (weight),
        .post_spike  (post_spike),
        .membrane    (membrane),
        .refractory  (refractory),
        .spike_count (spike_count)
    );

    lif_post_neuron #(.THRESHOLD(255)) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en_b),
        .pre_spike   (pre_b),
        .weight      (weight_b),
        .post_spike  (post_b),
        .membrane    (membrane_b),
        .refractory  (refr_b),
        .spike_count (count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int bb;
        logic prev;

        rst_n = 1'b0; en = 1'b1; pre_spike = 4'b1111; weight = 16'hFFFF;
        en_b = 1'b1; pre_b = 4'b1111; weight_b = 16'hFFFF;
        step(); step();
        check("rst_post", post_spike, 0);
        check("rst_mem", membrane, 0);
        check("rst_refr", refractory, 0);
        check("rst_cnt", spike_count, 0);
        check("rst_mem_b", membrane_b, 0);
        check("rst_cnt_b", count_b, 0);
        pre_spike = 4'b0000; pre_b = 4'b0000;
        rst_n = 1'b1;
        step();
        check("idle_mem", membrane, 0);

        // Single supra-threshold event
        pre_spike = 4'b1111; weight = 16'hFFFF;
        step();
        pre_spike = 4'b0000;
        check("fire_post", post_spike, 1);
        check("fire_mem", membrane, 0);
        check("fire_refr", refractory, 1);
        check("fire_cnt", spike_count, 1);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("refr_hold", refractory, 1);
            check("refr_post", post_spike, 0);
            check("refr_mem", membrane, 0);
        end
        step();
        check("refr_exit", refractory, 0);

        // Leak decay, with an en=0 hold in the middle
        weight = 16'hA000; pre_spike = 4'b0001;
        step();
        check("leak_load", membrane, 10);
        pre_spike = 4'b0000; en = 1'b0;
        step(); check("en0_hold", membrane, 10);
        step(); check("en0_hold", membrane, 10);
        en = 1'b1;
        for (int v = 9; v >= 0; v--) begin
            step();
            check("leak", membrane, v);
        end
        step(); check("leak_floor", membrane, 0);
        step(); check("leak_floor", membrane, 0);

        // Accumulation
        pre_spike = 4'b0001;
        step(); check("acc1", membrane, 10);
        step(); check("acc2", membrane, 19);
        step(); check("acc3", membrane, 28);
        step();
        check("acc_fire", post_spike, 1);
        check("acc_mem", membrane, 0);
        check("acc_cnt", spike_count, 2);
        pre_spike = 4'b0000;
        for (int i = 0; i < 5; i++) step();
        check("acc_exit", refractory, 0);

        // Periodic firing and refractory stretch
        pre_spike = 4'b1111; weight = 16'hFFFF;
        step();
        check("per_fire0", post_spike, 1);
        for (int i = 1; i <= 12; i++) begin
            step();
            check("per_post", post_spike, (i % 6 == 0) ? 1 : 0);
            check("per_mem", membrane, 0);
        end
        check("per_cnt", spike_count, 5);
        step(); step();
        en = 1'b0;
        step(); step(); step();
        check("stretch_refr", refractory, 1);
        en = 1'b1;
        for (int i = 6; i <= 9; i++) begin
            step();
            check("stretch_post", post_spike, (i == 9) ? 1 : 0);
            check("stretch_mem", membrane, 0);
        end
        check("stretch_cnt", spike_count, 6);
        pre_spike = 4'b0000;
        for (int i = 0; i < 5; i++) step();
        check("stretch_exit", refractory, 0);

        // Membrane saturation at THRESHOLD=255
        pre_b = 4'b1111;
        step(); check("sat1", membrane_b, 60);
        step(); check("sat2", membrane_b, 119);
        step(); check("sat3", membrane_b, 178);
        step(); check("sat4", membrane_b, 237);
        step();
        check("sat_fire", post_b, 1);
        check("sat_mem", membrane_b, 0);
        check("sat_cnt", count_b, 1);
        pre_b = 4'b0000;

        // 300 fires saturate the spike counter
        pre_spike = 4'b1111;
        pulses = 0; bb = 0; prev = 1'b0;
        for (int i = 0; i < 1800; i++) begin
            step();
            if (post_spike) pulses++;
            if (post_spike && prev) bb++;
            prev = post_spike;
        end
        check("long_pulses", pulses, 300);
        check("long_backtoback", bb, 0);
        check("cnt_sat", spike_count, 255);

        // Reset mid-refractory
        step();
        check("mid_refr", refractory, 1);
        rst_n = 1'b0;
        step();
        check("rst2_refr", refractory, 0);
        check("rst2_post", post_spike, 0);
        check("rst2_cnt", spike_count, 0);
        check("rst2_mem", membrane, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
